// File: rtl/arm_ctrl_pkg.sv
// Shared encodings and the decoded-control bundle for the ARM-subset control decoder.
package arm_ctrl_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    typedef struct packed {
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       no_write;
        logic [1:0] alu_control;
        logic [1:0] flag_w;
        logic       data_src;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        pcs:         1'b0,
        reg_w:       1'b0,
        mem_w:       1'b0,
        mem_to_reg:  1'b0,
        alu_src:     1'b0,
        imm_src:     2'b00,
        reg_src:     2'b00,
        no_write:    1'b0,
        alu_control: 2'b00,
        flag_w:      2'b00,
        data_src:    1'b0
    };

endpackage

// File: rtl/arm_ctrl_comb.sv
// Combinational main decode, ALU decode and PC-source logic producing one ctrl_t.
module arm_ctrl_comb
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] rd,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    logic       branch_s;
    logic       alu_op_s;
    logic       reg_w_s;
    logic       mem_w_s;
    logic       mem_to_reg_s;
    logic       alu_src_s;
    logic [1:0] imm_src_s;
    logic [1:0] reg_src_s;
    logic       no_write_s;
    logic [1:0] alu_control_s;
    logic [1:0] flag_w_s;
    logic       data_src_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic       pcs_s;

    assign cmd_s   = funct[4:1];
    assign s_bit_s = funct[0];

    // Main decode: instruction class to datapath steering.
    always_comb begin
        branch_s     = 1'b0;
        alu_op_s     = 1'b0;
        reg_w_s      = 1'b0;
        mem_w_s      = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_s    = 1'b0;
        imm_src_s    = IMM_8;
        reg_src_s    = 2'b00;
        case (op)
            OP_DP: begin
                reg_w_s   = 1'b1;
                alu_op_s  = 1'b1;
                alu_src_s = funct[5];
            end
            OP_MEM: begin
                alu_src_s = 1'b1;
                imm_src_s = IMM_12;
                if (s_bit_s) begin
                    mem_to_reg_s = 1'b1;
                    reg_w_s      = 1'b1;
                end else begin
                    mem_w_s   = 1'b1;
                    reg_src_s = 2'b10;
                end
            end
            OP_BR: begin
                branch_s  = 1'b1;
                alu_src_s = 1'b1;
                imm_src_s = IMM_24;
                reg_src_s = 2'b01;
            end
            default: begin
                branch_s = 1'b0;
            end
        endcase
    end

    // ALU decode: operation select, flag update and write suppression for DP class.
    always_comb begin
        alu_control_s = ALU_ADD;
        flag_w_s      = 2'b00;
        no_write_s    = 1'b0;
        data_src_s    = 1'b0;
        if (alu_op_s) begin
            case (cmd_s)
                CMD_ADD: alu_control_s = ALU_ADD;
                CMD_SUB: alu_control_s = ALU_SUB;
                CMD_AND: alu_control_s = ALU_AND;
                CMD_ORR: alu_control_s = ALU_ORR;
                CMD_CMP: begin
                    alu_control_s = ALU_SUB;
                    no_write_s    = 1'b1;
                end
                CMD_MOV: data_src_s = 1'b1;
                default: no_write_s = 1'b1;
            endcase
            // CMP exists only to set flags, so it updates all of them regardless of S.
            if (cmd_s == CMD_CMP) begin
                flag_w_s = 2'b11;
            end else if (s_bit_s) begin
                flag_w_s = {1'b1, (cmd_s == CMD_ADD) || (cmd_s == CMD_SUB)};
            end else begin
                flag_w_s = 2'b00;
            end
        end else begin
            alu_control_s = ALU_ADD;
            flag_w_s      = 2'b00;
        end
    end

    assign pcs_s = branch_s | ((rd == 4'hF) & reg_w_s);

    // Collect the decoded fields into the output bundle.
    always_comb begin
        ctrl             = CTRL_RESET;
        ctrl.pcs         = pcs_s;
        ctrl.reg_w       = reg_w_s;
        ctrl.mem_w       = mem_w_s;
        ctrl.mem_to_reg  = mem_to_reg_s;
        ctrl.alu_src     = alu_src_s;
        ctrl.imm_src     = imm_src_s;
        ctrl.reg_src     = reg_src_s;
        ctrl.no_write    = no_write_s;
        ctrl.alu_control = alu_control_s;
        ctrl.flag_w      = flag_w_s;
        ctrl.data_src    = data_src_s;
    end

endmodule

// File: rtl/arm_ctrl_decoder.sv
// Registered control decoder: one cycle from instruction fields to control outputs.
module arm_ctrl_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Rd,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       NoWrite,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       DataSrc
);

    ctrl_t ctrl_s;
    ctrl_t ctrl_r;

    arm_ctrl_comb u_comb (
        .rd    (Rd),
        .op    (Op),
        .funct (Funct),
        .ctrl  (ctrl_s)
    );

    // Output register; reset forces every control to its inactive value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= CTRL_RESET;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign PCS        = ctrl_r.pcs;
    assign RegW       = ctrl_r.reg_w;
    assign MemW       = ctrl_r.mem_w;
    assign MemtoReg   = ctrl_r.mem_to_reg;
    assign ALUSrc     = ctrl_r.alu_src;
    assign ImmSrc     = ctrl_r.imm_src;
    assign RegSrc     = ctrl_r.reg_src;
    assign NoWrite    = ctrl_r.no_write;
    assign ALUControl = ctrl_r.alu_control;
    assign FlagW      = ctrl_r.flag_w;
    assign DataSrc    = ctrl_r.data_src;

endmodule

// File: tb/tb_arm_ctrl_decoder.sv
// Scoreboard bench for arm_ctrl_decoder: expectations queued at drive time, checked a cycle later.
module tb_arm_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Rd;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCS, RegW, MemW, MemtoReg, ALUSrc, NoWrite, DataSrc;
    logic [1:0] ImmSrc, RegSrc, ALUControl, FlagW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t sb[$];

    always #5 clk = ~clk;

    arm_ctrl_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rd         (Rd),
        .Op         (Op),
        .Funct      (Funct),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .NoWrite    (NoWrite),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .DataSrc    (DataSrc)
    );

    // Field order: PCS RegW MemW MemtoReg ALUSrc ImmSrc RegSrc NoWrite ALUControl FlagW DataSrc
    wire [14:0] obs = {PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc,
                       NoWrite, ALUControl, FlagW, DataSrc};

    function automatic vec_t mk(input logic [3:0] rd, input logic [1:0] op,
                                input logic [5:0] funct, input string name,
                                input logic pcs, input logic regw, input logic memw,
                                input logic m2r, input logic alusrc, input logic [1:0] imm,
                                input logic [1:0] rsrc, input logic nw, input logic [1:0] alu,
                                input logic [1:0] flag, input logic ds);
        vec_t v;
        v.rd    = rd;
        v.op    = op;
        v.funct = funct;
        v.name  = name;
        v.exp   = {pcs, regw, memw, m2r, alusrc, imm, rsrc, nw, alu, flag, ds};
        return v;
    endfunction

    task automatic test_reset();
        logic [14:0] br_exp;
        br_exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0};
        rst_n = 1'b0;
        Rd    = 4'h0;
        Op    = 2'b10;
        Funct = 6'b000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 15'd0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_release_no_edge: got %b expected %b", obs, 15'd0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== br_exp) begin
            errors++;
            $display("FAIL first_edge_branch: got %b expected %b", obs, br_exp);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", obs, 15'd0);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== br_exp) begin
            errors++;
            $display("FAIL post_async_branch: got %b expected %b", obs, br_exp);
        end
    endtask

    task automatic test_dp();
        vec_t tbl[$];
        vec_t v;
        tbl.push_back(mk(4'h1, 2'b00, 6'b001000, "add_reg",   1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'h1, 2'b00, 6'b100101, "subs_imm",  1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b01,2'b11,1'b0));
        tbl.push_back(mk(4'h0, 2'b00, 6'b010101, "cmp_s",     1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b01,2'b11,1'b0));
        tbl.push_back(mk(4'h0, 2'b00, 6'b010100, "cmp_nos",   1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b01,2'b11,1'b0));
        tbl.push_back(mk(4'h2, 2'b00, 6'b000001, "ands",      1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b10,2'b10,1'b0));
        tbl.push_back(mk(4'hF, 2'b00, 6'b111010, "mov_pc",    1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1));
        tbl.push_back(mk(4'hF, 2'b00, 6'b111000, "orr_pc",    1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b11,2'b00,1'b0));
        tbl.push_back(mk(4'h4, 2'b00, 6'b011001, "orrs",      1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b10,1'b0));
        tbl.push_back(mk(4'h5, 2'b00, 6'b001001, "adds",      1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b11,1'b0));
        tbl.push_back(mk(4'h2, 2'b00, 6'b000010, "eor_undef", 1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'h2, 2'b00, 6'b000011, "eors_undef",1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b10,1'b0));
        for (int i = 0; i <= tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (i < tbl.size()) begin
                Rd = tbl[i].rd; Op = tbl[i].op; Funct = tbl[i].funct;
                sb.push_back(tbl[i]);
            end
            @(negedge clk);
            if (sb.size() > ((i < tbl.size()) ? 1 : 0)) begin
                v = sb.pop_front();
                checks++;
                if (obs !== v.exp) begin
                    errors++;
                    $display("FAIL dp_%s: got %b expected %b", v.name, obs, v.exp);
                end
            end
        end
    endtask

    task automatic test_mem();
        vec_t tbl[$];
        vec_t v;
        tbl.push_back(mk(4'h3, 2'b01, 6'b011001, "ldr",    1'b0,1'b1,1'b0,1'b1,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'h3, 2'b01, 6'b011000, "str",    1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,2'b10,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'hF, 2'b01, 6'b011001, "ldr_pc", 1'b1,1'b1,1'b0,1'b1,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'hF, 2'b01, 6'b011000, "str_r15",1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,2'b10,1'b0,2'b00,2'b00,1'b0));
        for (int i = 0; i <= tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (i < tbl.size()) begin
                Rd = tbl[i].rd; Op = tbl[i].op; Funct = tbl[i].funct;
                sb.push_back(tbl[i]);
            end
            @(negedge clk);
            if (sb.size() > ((i < tbl.size()) ? 1 : 0)) begin
                v = sb.pop_front();
                checks++;
                if (obs !== v.exp) begin
                    errors++;
                    $display("FAIL mem_%s: got %b expected %b", v.name, obs, v.exp);
                end
            end
        end
    endtask

    task automatic test_branch_undef();
        vec_t tbl[$];
        vec_t v;
        tbl.push_back(mk(4'hF, 2'b10, 6'b101010, "branch",  1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,2'b01,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'hF, 2'b11, 6'b111111, "op11",    1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'h0, 2'b10, 6'b010101, "branch2", 1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,2'b01,1'b0,2'b00,2'b00,1'b0));
        tbl.push_back(mk(4'h7, 2'b11, 6'b010101, "op11_cmp",1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b0));
        for (int i = 0; i <= tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (i < tbl.size()) begin
                Rd = tbl[i].rd; Op = tbl[i].op; Funct = tbl[i].funct;
                sb.push_back(tbl[i]);
            end
            @(negedge clk);
            if (sb.size() > ((i < tbl.size()) ? 1 : 0)) begin
                v = sb.pop_front();
                checks++;
                if (obs !== v.exp) begin
                    errors++;
                    $display("FAIL br_%s: got %b expected %b", v.name, obs, v.exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_mem();
        test_branch_undef();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected %0d", sb.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_ctrl_decoder.md
Name: arm_ctrl_decoder

Overview:
- Registered control-signal decoder for the ARM-subset single-cycle datapath.
- Inputs: instruction fields Rd, Op and Funct.
- Function: main (instruction-class) decode, ALU decode and PC-source logic, combined into one block.
- All outputs are registered, giving one clock of latency. The block sits between instruction fetch and the datapath/condition logic.

Parameters:
- None. All field widths and encodings are fixed constants.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- Rd, input, 4: destination register field Instr[15:12].
- Op, input, 2: instruction class Instr[27:26].
- Funct, input, 6: Instr[25:20]. Bit 5 = I, bits 4:1 = cmd, bit 0 = S/L.
- PCS, output, 1: PC written by this instruction.
- RegW, output, 1: register-file write.
- MemW, output, 1: data-memory write.
- MemtoReg, output, 1: result comes from memory.
- ALUSrc, output, 1: 1 = SrcB is ExtImm, 0 = register.
- ImmSrc, output, 2: extend mode. 00 = imm8, 01 = imm12, 10 = imm24 branch.
- RegSrc, output, 2: bit0 = RA1 from PC (R15), bit1 = RA2 from Rd.
- NoWrite, output, 1: suppress register write (compare or unsupported).
- ALUControl, output, 2: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- FlagW, output, 2: bit1 = update NZ, bit0 = update CV.
- DataSrc, output, 1: result bypasses the ALU and equals SrcB (MOV).

Behaviour:
- Combinational decode is captured into output registers on each rising clk. Latency is exactly 1 cycle; a new decode is accepted every cycle.
- rst_n low clears every output to 0 immediately, independent of clk. Outputs stay 0 until the first rising edge after rst_n goes high.
- Main decode, listed as Branch/MemtoReg/MemW/ALUSrc/ImmSrc/RegW/RegSrc/ALUOp:
  - Op=00, I=0 (DP reg): 0/0/0/0/00/1/00/1
  - Op=00, I=1 (DP imm): 0/0/0/1/00/1/00/1
  - Op=01, Funct[0]=0 (STR): 0/0/1/1/01/0/10/0
  - Op=01, Funct[0]=1 (LDR): 0/1/0/1/01/1/00/0
  - Op=10 (B): 1/0/0/1/10/0/01/0
  - Op=11: all zero.
  - Branch and ALUOp are internal signals only.
- ALU decode when ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0, DataSrc=0.
- ALU decode when ALUOp=1, by cmd:
  - 0100 ADD: ALUControl=00.
  - 0010 SUB: ALUControl=01.
  - 0000 AND: ALUControl=10.
  - 1100 ORR: ALUControl=11.
  - 1010 CMP: ALUControl=01, NoWrite=1.
  - 1101 MOV: ALUControl=00, DataSrc=1.
  - Any other cmd: ALUControl=00, NoWrite=1, DataSrc=0.
- FlagW when ALUOp=1:
  - S=0: FlagW=00.
  - S=1: FlagW[1]=1. FlagW[0]=1 only for ADD, SUB and CMP.
  - CMP always gives FlagW=11, even with S=0.
- PCS = Branch OR (Rd==4'hF AND RegW). Both terms are taken from the same combinational decode. NoWrite does not mask PCS or RegW; conditional gating happens downstream.
- There are no don't-care outputs; every unlisted bit decodes to 0.

Decomposition:
- Package arm_ctrl_pkg holds:
  - Op class constants: OP_DP, OP_MEM, OP_BR.
  - cmd constants: CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_CMP, CMD_MOV.
  - ALUControl encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR.
  - ImmSrc encodings.
  - A packed struct of all decoded outputs.
- One natural sub-module, arm_ctrl_comb: purely combinational main decode, ALU decode and PC logic, producing the struct. The top module only registers that struct with async reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with Op=10 held. All outputs go 0 with no clock. Release, then one edge later PCS=1 and ImmSrc=10.
- ADD reg then SUBS imm on consecutive cycles:
  - Op=00, Funct=001000, Rd=1 gives RegW=1, ALUSrc=0, ALUControl=00, FlagW=00, PCS=0.
  - The next cycle, Funct=100101 gives ALUSrc=1, ALUControl=01, FlagW=11.
  - Each result appears exactly one cycle after its input.
- CMP: Op=00, Funct=010101 gives NoWrite=1, ALUControl=01, FlagW=11, RegW=1. ANDS (Funct=000001) gives ALUControl=10, FlagW=10.
- MOV to PC: Op=00, Funct=111010, Rd=1111 gives DataSrc=1, ALUSrc=1, PCS=1.
- Memory instructions:
  - LDR (Op=01, Funct=011001) gives MemtoReg=1, RegW=1, ImmSrc=01, ALUControl=00.
  - STR (Funct=011000) gives MemW=1, RegW=0, RegSrc=10.
  - LDR with Rd=15 gives PCS=1.
- Branch and undefined:
  - Op=10 gives PCS=1, RegSrc=01, ImmSrc=10, RegW=0.
  - Op=11 gives all outputs 0.
  - Op=00 with cmd=0001 (EOR) gives NoWrite=1, ALUControl=00.
